mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access stage between the execute stage and the 256x8 data memory.
- Accepts one load/store request per handshake and computes the effective address as base + offset, modulo 256.
- Drives the data-memory strobes for exactly one cycle per access.
- Returns load data to register writeback through a valid/ready handshake.

Parameters:
- REG_IDX_W, 2, width of the destination register index (4 registers).
- ADDR_LIMIT, 8'hEF, highest legal effective address; used only with ADDR_BOUNDS_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  execute stage presents a request.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_base  input  8  base address operand.
- req_offset  input  8  offset operand.
- req_wdata  input  8  store data.
- req_rd  input  REG_IDX_W  load destination register.
- mem_address  output  8  data-memory address.
- mem_write_data  output  8  data-memory write data.
- mem_write  output  1  data-memory write strobe.
- mem_read  output  1  data-memory read enable.
- mem_read_data  input  8  data-memory read data, combinational from mem_address/mem_read.
- wb_valid  output  1  load result available.
- wb_ready  input  1  writeback accepts the result.
- wb_data  output  8  loaded byte.
- wb_rd  output  REG_IDX_W  destination register of the load.
- store_done  output  1  one-cycle pulse: store committed.
- busy  output  1  state != IDLE.
- fault  output  1  address-bounds fault; tied 0 without ADDR_BOUNDS_EN.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset:
  - rst_n low forces state IDLE asynchronously.
  - All registered outputs and latches go to 0: wb_valid, wb_data, wb_rd, store_done, fault, latched addr/wdata/rd/write.
  - Reset takes effect mid-operation. A store in ACCESS is not written if reset asserts before its edge. A pending wb_valid drops immediately.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid high, the unit latches:
    - addr = (req_base + req_offset)[7:0], carry discarded;
    - req_wdata, req_rd, req_write.
  - It then moves to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = latched addr.
  - Load: mem_read = 1. Store: mem_write = 1 and mem_write_data = latched wdata.
  - At the closing edge, a load captures mem_read_data into wb_data and the latched rd into wb_rd, then moves to RESP.
  - At the closing edge, a store sets store_done = 1 for one cycle and returns to IDLE.
- RESP:
  - wb_valid = 1; wb_data and wb_rd are held stable; req_ready = 0.
  - On an edge with wb_ready high, the unit clears wb_valid and returns to IDLE.
  - With wb_ready low, it holds indefinitely.
- Outside ACCESS: mem_read, mem_write, mem_address and mem_write_data are all 0.
- Latency, for a request accepted at edge N:
  - mem strobes are high between edges N and N+1;
  - the memory is written at edge N+1;
  - store_done is high between N+1 and N+2;
  - wb_valid rises at N+1.
- Throughput:
  - Back-to-back stores: one every 2 cycles.
  - Back-to-back loads with wb_ready held high: one every 3 cycles.
- busy = 1 in ACCESS and RESP.
- req_valid while not ready is ignored. The request must be held by the producer.

Optional Feature:
- Macro: ADDR_BOUNDS_EN.
- Defined: at acceptance, an effective address greater than ADDR_LIMIT is a fault. ACCESS still lasts one cycle but asserts no mem_read or mem_write.
  - Faulting load: enters RESP with wb_data = 0 and fault = 1 for as long as wb_valid is high.
  - Faulting store: pulses store_done with fault = 1 in the same cycle; memory is unchanged.
  - fault clears on the next request acceptance or on reset.
- Not defined: fault is tied 0, and every address 0x00-0xFF is accessed normally.

Test Plan:
- Load, memory preloaded mem[0x0A] = 20, with base = 0x08, offset = 0x02, rd = 1, wb_ready = 1 -> mem_read high one cycle at address 0x0A; wb_valid one cycle later; wb_data = 20, wb_rd = 1.
- Store wdata = 0x55 to base = 0x30, offset = 0, then load 0x30 -> mem_write one cycle, store_done one pulse; the load returns 0x55; req_ready low exactly 1 cycle between the ops.
- Wrap-around: base = 0xF0, offset = 0x20 -> mem_address = 0x10.
- Backpressure: load with wb_ready low for 3 cycles -> wb_valid/wb_data stable, req_ready = 0, busy = 1; return to IDLE on the edge where wb_ready = 1.
- Reset during a store's ACCESS cycle -> outputs 0 immediately, memory location unchanged, req_ready = 1 after rst_n releases.
- ADDR_BOUNDS_EN defined: store 0xAA to 0xF5 -> no mem_write, store_done = 1 with fault = 1; load 0xF5 -> wb_data = 0, fault = 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage between execute and a 256x8 data memory.
// Optional ADDR_BOUNDS_EN macro enables effective-address range checking against ADDR_LIMIT.
module mem_access_unit #(
  parameter int         REG_IDX_W  = 2,
  parameter logic [7:0] ADDR_LIMIT = 8'hEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [7:0]           req_base,
  input  logic [7:0]           req_offset,
  input  logic [7:0]           req_wdata,
  input  logic [REG_IDX_W-1:0] req_rd,
  output logic [7:0]           mem_address,
  output logic [7:0]           mem_write_data,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [7:0]           mem_read_data,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [7:0]           wb_data,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 store_done,
  output logic                 busy,
  output logic                 fault
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_next;
  logic [7:0] addr, wdata, sum;
  logic [REG_IDX_W-1:0] rd;
  logic wr, flt, bad, accept, acc;
  assign sum = req_base + req_offset;
  assign accept = state == IDLE && req_valid;
  assign acc = state == ACCESS;
`ifdef ADDR_BOUNDS_EN
  logic fault_q;
  assign bad = sum > ADDR_LIMIT;
  assign fault = fault_q;
  // fault persists past the response until the next request is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fault_q <= 1'b0;
    else if (accept) fault_q <= 1'b0;
    else if (acc) fault_q <= flt;
`else
  logic unused_limit;
  assign unused_limit = ^ADDR_LIMIT;
  assign bad = 1'b0;
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE ? (req_valid ? ACCESS : IDLE) :
                 state == ACCESS ? (wr ? IDLE : RESP) :
                 (wb_ready ? IDLE : RESP);
    req_ready = state == IDLE;
    busy = state != IDLE;
    wb_valid = state == RESP;
    mem_address = acc ? addr : 8'h00;
    mem_write_data = acc && wr ? wdata : 8'h00;
    mem_write = acc && wr && !flt;
    mem_read = acc && !wr && !flt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= 8'h00;
      wdata <= 8'h00;
      rd <= '0;
      wr <= 1'b0;
      flt <= 1'b0;
      wb_data <= 8'h00;
      wb_rd <= '0;
      store_done <= 1'b0;
    end else begin
      store_done <= acc && wr;
      if (accept) begin
        addr <= sum;
        wdata <= req_wdata;
        rd <= req_rd;
        wr <= req_write;
        flt <= bad;
      end
      if (acc && !wr) begin
        wb_data <= flt ? 8'h00 : mem_read_data;
        wb_rd <= rd;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a 256x8 memory model.
module tb_mem_access_unit;
  logic clk, rst_n, init;
  logic req_valid, req_ready, req_write;
  logic [7:0] req_base, req_offset, req_wdata;
  logic [1:0] req_rd, wb_rd;
  logic [7:0] mem_address, mem_write_data, mem_read_data, wb_data;
  logic mem_write, mem_read, wb_valid, wb_ready, store_done, busy, fault;
  logic [7:0] mem [256];
  int vectors = 0;
  int errors = 0;
  logic [7:0] exp_f5, exp_fault, exp_wr, exp_rdata;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .store_done(store_done), .busy(busy),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h0A] <= 8'd20;
      mem[8'h10] <= 8'h3C;
      mem[8'h40] <= 8'h77;
      mem[8'hF5] <= 8'h11;
    end else if (mem_write) mem[mem_address] <= mem_write_data;

  assign mem_read_data = mem_read ? mem[mem_address] : 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [7:0] b, input logic [7:0] o,
                     input logic [7:0] d, input logic [1:0] r);
    req_valid = 1'b1; req_write = w; req_base = b; req_offset = o; req_wdata = d; req_rd = r;
  endtask

  initial begin
`ifdef ADDR_BOUNDS_EN
    exp_f5 = 8'h11; exp_fault = 8'h01; exp_wr = 8'h00; exp_rdata = 8'h00;
`else
    exp_f5 = 8'hAA; exp_fault = 8'h00; exp_wr = 8'h01; exp_rdata = 8'hAA;
`endif
    rst_n = 1'b0; init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_base = 8'h00; req_offset = 8'h00;
    req_wdata = 8'h00; req_rd = 2'd0; wb_ready = 1'b1;
    step();
    step();
    init = 1'b0;
    chk("rst_ready", {7'b0, req_ready}, 8'h01);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_wb_valid", {7'b0, wb_valid}, 8'h00);
    chk("rst_store_done", {7'b0, store_done}, 8'h00);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_fault", {7'b0, fault}, 8'h00);
    rst_n = 1'b1;
    step();
    // load 0x08+0x02 -> mem[0x0A] = 20 into r1
    req(1'b0, 8'h08, 8'h02, 8'h00, 2'd1);
    step();
    req_valid = 1'b0;
    chk("ld_mem_read", {7'b0, mem_read}, 8'h01);
    chk("ld_mem_addr", mem_address, 8'h0A);
    chk("ld_mem_write", {7'b0, mem_write}, 8'h00);
    chk("ld_ready", {7'b0, req_ready}, 8'h00);
    chk("ld_busy", {7'b0, busy}, 8'h01);
    step();
    chk("ld_wb_valid", {7'b0, wb_valid}, 8'h01);
    chk("ld_wb_data", wb_data, 8'd20);
    chk("ld_wb_rd", {6'b0, wb_rd}, 8'h01);
    chk("ld_read_off", {7'b0, mem_read}, 8'h00);
    step();
    chk("ld_done_valid", {7'b0, wb_valid}, 8'h00);
    chk("ld_done_ready", {7'b0, req_ready}, 8'h01);
    // store 0x55 to 0x30, then load it straight back
    req(1'b1, 8'h30, 8'h00, 8'h55, 2'd0);
    step();
    chk("st_mem_write", {7'b0, mem_write}, 8'h01);
    chk("st_mem_addr", mem_address, 8'h30);
    chk("st_mem_wdata", mem_write_data, 8'h55);
    chk("st_mem_read", {7'b0, mem_read}, 8'h00);
    chk("st_ready_low", {7'b0, req_ready}, 8'h00);
    req(1'b0, 8'h30, 8'h00, 8'h00, 2'd2);
    step();
    chk("st_done", {7'b0, store_done}, 8'h01);
    chk("st_ready_back", {7'b0, req_ready}, 8'h01);
    chk("st_write_off", {7'b0, mem_write}, 8'h00);
    chk("st_mem_value", mem[8'h30], 8'h55);
    step();
    req_valid = 1'b0;
    chk("st_done_pulse", {7'b0, store_done}, 8'h00);
    chk("ld2_mem_read", {7'b0, mem_read}, 8'h01);
    step();
    chk("ld2_wb_data", wb_data, 8'h55);
    chk("ld2_wb_rd", {6'b0, wb_rd}, 8'h02);
    step();
    // wrap-around address then backpressure
    req(1'b0, 8'hF0, 8'h20, 8'h00, 2'd3);
    step();
    req_valid = 1'b0; wb_ready = 1'b0;
    chk("wrap_addr", mem_address, 8'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {7'b0, wb_valid}, 8'h01);
      chk("bp_data", wb_data, 8'h3C);
      chk("bp_ready", {7'b0, req_ready}, 8'h00);
      chk("bp_busy", {7'b0, busy}, 8'h01);
    end
    wb_ready = 1'b1;
    step();
    chk("bp_release_valid", {7'b0, wb_valid}, 8'h00);
    chk("bp_release_ready", {7'b0, req_ready}, 8'h01);
    // reset in the middle of a store's ACCESS cycle
    req(1'b1, 8'h40, 8'h00, 8'h99, 2'd0);
    step();
    req_valid = 1'b0;
    chk("rs_write_before", {7'b0, mem_write}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_write_now", {7'b0, mem_write}, 8'h00);
    chk("rs_addr_now", mem_address, 8'h00);
    chk("rs_busy_now", {7'b0, busy}, 8'h00);
    step();
    chk("rs_mem_kept", mem[8'h40], 8'h77);
    chk("rs_store_done", {7'b0, store_done}, 8'h00);
    rst_n = 1'b1;
    step();
    chk("rs_ready_after", {7'b0, req_ready}, 8'h01);
    // high address: faulting when bounds checking is built in
    req(1'b1, 8'hF5, 8'h00, 8'hAA, 2'd0);
    step();
    req_valid = 1'b0;
    chk("hi_st_write", {7'b0, mem_write}, exp_wr);
    step();
    chk("hi_st_done", {7'b0, store_done}, 8'h01);
    chk("hi_st_fault", {7'b0, fault}, exp_fault);
    chk("hi_st_mem", mem[8'hF5], exp_f5);
    req(1'b0, 8'hF0, 8'h05, 8'h00, 2'd1);
    step();
    req_valid = 1'b0;
    chk("hi_ld_read", {7'b0, mem_read}, exp_wr);
    step();
    chk("hi_ld_valid", {7'b0, wb_valid}, 8'h01);
    chk("hi_ld_data", wb_data, exp_rdata);
    chk("hi_ld_fault", {7'b0, fault}, exp_fault);
    step();
    chk("hi_ld_idle", {7'b0, req_ready}, 8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
